// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store engine issuing one word-aligned req/ack bus transfer per request
module memory_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next;
  logic        req, legal, f_ok, a_ok, timeout, err_r;
  logic [15:0] cnt;
  logic [2:0]  f3_r;
  logic [1:0]  a_r;
  logic [3:0]  strb;
  logic [31:0] wdata, ext;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    req = memory_read | memory_write;
    f_ok = memory_write ? (funct3 inside {3'b000, 3'b001, 3'b010})
                        : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    a_ok = funct3[1:0] == 2'b01 ? !address[0] :
           funct3[1:0] == 2'b10 ? address[1:0] == 2'b00 : 1'b1;
    legal = f_ok & a_ok;
    strb = funct3[1:0] == 2'b00 ? 4'b0001 << address[1:0] :
           funct3[1:0] == 2'b01 ? 4'b0011 << address[1:0] : 4'b1111;
    wdata = funct3[1:0] == 2'b00 ? {4{write_data[7:0]}} :
            funct3[1:0] == 2'b01 ? {2{write_data[15:0]}} : write_data;
    b = bus_rdata[{a_r, 3'b000} +: 8];
    h = bus_rdata[{a_r[1], 4'b0000} +: 16];
    ext = f3_r[1:0] == 2'b00 ? {{24{~f3_r[2] & b[7]}}, b} :
          f3_r[1:0] == 2'b01 ? {{16{~f3_r[2] & h[15]}}, h} : bus_rdata;
    timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
    next = state;
    case (state)
      IDLE: next = req ? (legal ? WAIT : DONE) : IDLE;
      WAIT: next = (bus_ack || timeout) ? DONE : WAIT;
      default: next = IDLE;
    endcase
    busy = state == WAIT;
    bus_req = state == WAIT;
    done = state == DONE;
    err = done & err_r;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      err_r <= 1'b0;
      read_data <= '0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      f3_r <= '0;
      a_r <= '0;
    end else begin
      state <= next;
      if (state == IDLE && req) begin
        err_r <= !legal;
        if (legal) begin
          cnt <= '0;
          f3_r <= funct3;
          a_r <= address[1:0];
          bus_we <= memory_write;
          bus_addr <= {address[31:2], 2'b00};
          bus_wstrb <= strb & {4{memory_write}};
          bus_wdata <= wdata;
        end
      end
      if (state == WAIT) begin
        cnt <= cnt + 16'd1;
        err_r <= !bus_ack;
        if (bus_ack && !bus_we) read_data <= ext;
      end
    end
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: vector table with scoreboard, plus reset and timeout sequences
module tb_memory_access_unit;
  logic        clk = 1'b0, reset, memory_read, memory_write, busy, done, err, bus_req, bus_we, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] address, write_data, read_data, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  always #5 clk = ~clk;
  memory_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
    .funct3(funct3), .address(address), .write_data(write_data), .read_data(read_data),
    .busy(busy), .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  typedef struct {
    logic rd, wr; logic [2:0] f3; logic [31:0] addr, wd, rdata; int lat;
    logic e_err; logic [31:0] e_rd; logic e_we; logic [3:0] e_strb; logic [31:0] e_wdata;
    int e_cyc, e_reqs;
  } vec_t;
  vec_t tab[16];
  vec_t sbq[$];
  int cmp = 0, bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    cmp++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic run(input vec_t v, input int idx);
    vec_t x;
    int cyc, reqs;
    @(negedge clk);
    memory_read = v.rd; memory_write = v.wr; funct3 = v.f3;
    address = v.addr; write_data = v.wd; bus_rdata = v.rdata;
    sbq.push_back(v);
    @(posedge clk); #1;
    memory_read = 1'b0; memory_write = 1'b0;
    cyc = 1; reqs = 0;
    while (!done && cyc < 20) begin
      chk($sformatf("v%0d busy", idx), busy, v.e_reqs != 0);
      if (bus_req) begin
        if (reqs == 0) begin
          chk($sformatf("v%0d bus_we", idx), bus_we, v.e_we);
          chk($sformatf("v%0d bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d bus_wstrb", idx), bus_wstrb, v.e_strb);
          if (v.e_we) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.e_wdata);
        end
        if (reqs == v.lat) bus_ack = 1'b1;
        reqs++;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      cyc++;
    end
    x = sbq.pop_front();
    chk($sformatf("v%0d latency", idx), cyc, x.e_cyc);
    chk($sformatf("v%0d req_cycles", idx), reqs, x.e_reqs);
    chk($sformatf("v%0d err", idx), err, x.e_err);
    chk($sformatf("v%0d read_data", idx), read_data, x.e_rd);
    @(posedge clk); #1;
    chk($sformatf("v%0d done_pulse", idx), done, 1'b0);
  endtask
  initial begin
    tab[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 2, 1};
    tab[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FFFF7F, 1, 1'b0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0, 3, 2};
    tab[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1'b0, 32'h00000080, 1'b0, 4'h0, 32'h0, 2, 1};
    tab[3]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2, 1'b0, 32'h00000080, 1'b1, 4'b1100, 32'hABCDABCD, 4, 3};
    tab[4]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h00000080, 1'b0, 4'h0, 32'h0, 1, 0};
    tab[5]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h00000080, 1'b0, 4'h0, 32'h0, 1, 0};
    tab[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0, 1'b0, 32'hFFFF8001, 1'b0, 4'h0, 32'h0, 2, 1};
    tab[7]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F234, 0, 1'b0, 32'h0000F234, 1'b0, 4'h0, 32'h0, 2, 1};
    tab[8]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'hA5, 32'h0, 0, 1'b0, 32'h0000F234, 1'b1, 4'b0010, 32'hA5A5A5A5, 2, 1};
    tab[9]  = '{1'b0, 1'b1, 3'b010, 32'h200, 32'h11223344, 32'h0, 1, 1'b0, 32'h0000F234, 1'b1, 4'hF, 32'h11223344, 3, 2};
    tab[10] = '{1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'h0000F234, 1'b1, 4'hF, 32'hCAFEF00D, 2, 1};
    tab[11] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h5, 32'h0, 0, 1'b1, 32'h0000F234, 1'b0, 4'h0, 32'h0, 1, 0};
    tab[12] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0000F234, 1'b0, 4'h0, 32'h0, 1, 0};
    tab[13] = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 32'h12345678, 99, 1'b1, 32'h0000F234, 1'b0, 4'h0, 32'h0, 5, 4};
    tab[14] = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 0, 1'b0, 32'h0000007F, 1'b0, 4'h0, 32'h0, 2, 1};
    tab[15] = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h00800000, 0, 1'b0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0, 2, 1};
    reset = 1'b1; memory_read = 1'b0; memory_write = 1'b0; funct3 = 3'b0;
    address = '0; write_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst done", done, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst bus_req", bus_req, 1'b0);
    chk("rst read_data", read_data, 32'h0);
    chk("rst bus_wstrb", bus_wstrb, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) run(tab[i], i);
    @(negedge clk);
    memory_read = 1'b1; funct3 = 3'b010; address = 32'h10C;
    @(posedge clk); #1;
    memory_read = 1'b0;
    chk("mid bus_req 1st", bus_req, 1'b1);
    @(posedge clk); #1;
    chk("mid bus_req 2nd", bus_req, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid rst bus_req", bus_req, 1'b0);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst done", done, 1'b0);
    chk("mid rst read_data", read_data, 32'h0);
    @(posedge clk); #1;
    chk("post rst done", done, 1'b0);
    chk("post rst bus_req", bus_req, 1'b0);
    run(tab[15], 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
